// File: rtl/rv32i_hazard_ctrl_pkg.sv
// Shared types and constants for the RV32I hazard controller.
package rv32i_hazard_pkg;

    localparam int unsigned XLEN_DEF  = 32;
    localparam int unsigned REG_W_DEF = 5;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    // Width of the flush down-counter, which holds at most FLUSH_CYCLES-1.
    function automatic int unsigned flush_cnt_w(input int unsigned flush_cycles);
        return (flush_cycles <= 2) ? 1 : $clog2(flush_cycles);
    endfunction

endpackage

// File: rtl/rv32i_hazard_ctrl_if.sv
// Decode-side bundle between the pipeline and the hazard controller.
interface rv32i_hazard_ctrl_if
    import rv32i_hazard_pkg::*;
#(
    parameter int unsigned XLEN    = XLEN_DEF,
    parameter int unsigned REG_W   = REG_W_DEF,
    parameter int unsigned NUM_FWD = 3,
    parameter int unsigned CNT_W   = 32
);

    logic                     id_valid;
    logic [REG_W-1:0]         id_rs1_reg;
    logic [REG_W-1:0]         id_rs2_reg;
    logic                     id_rs1_used;
    logic                     id_rs2_used;
    logic [XLEN-1:0]          id_rs1_data;
    logic [XLEN-1:0]          id_rs2_data;
    logic [NUM_FWD-1:0]       df_enable;
    logic [NUM_FWD*REG_W-1:0] df_reg;
    logic [NUM_FWD*XLEN-1:0]  df_data;
    logic [NUM_FWD-1:0]       df_pending;
    logic                     br_taken;

    logic [XLEN-1:0]          rs1_fwd_data;
    logic [XLEN-1:0]          rs2_fwd_data;
    logic                     stall_if_id;
    logic                     bubble_ex;
    logic                     flush_if_id;
    logic [CNT_W-1:0]         stall_cnt;
    logic [CNT_W-1:0]         flush_cnt;
    logic                     busy;

    // Pipeline side
    modport master (
        output id_valid, id_rs1_reg, id_rs2_reg, id_rs1_used, id_rs2_used,
        output id_rs1_data, id_rs2_data, df_enable, df_reg, df_data, df_pending, br_taken,
        input  rs1_fwd_data, rs2_fwd_data, stall_if_id, bubble_ex, flush_if_id,
        input  stall_cnt, flush_cnt, busy
    );

    // Hazard controller side
    modport slave (
        input  id_valid, id_rs1_reg, id_rs2_reg, id_rs1_used, id_rs2_used,
        input  id_rs1_data, id_rs2_data, df_enable, df_reg, df_data, df_pending, br_taken,
        output rs1_fwd_data, rs2_fwd_data, stall_if_id, bubble_ex, flush_if_id,
        output stall_cnt, flush_cnt, busy
    );

endinterface

// File: rtl/rv32i_hazard_ctrl_fwd_select.sv
// Priority forwarding match and operand mux for one source register.
module rv32i_fwd_select
    import rv32i_hazard_pkg::*;
#(
    parameter int unsigned XLEN    = XLEN_DEF,
    parameter int unsigned REG_W   = REG_W_DEF,
    parameter int unsigned NUM_FWD = 3
) (
    input  logic [REG_W-1:0]         rs_reg,
    input  logic [XLEN-1:0]          rf_data,
    input  logic [NUM_FWD-1:0]       df_enable,
    input  logic [NUM_FWD*REG_W-1:0] df_reg,
    input  logic [NUM_FWD*XLEN-1:0]  df_data,
    input  logic [NUM_FWD-1:0]       df_pending,
    output logic [XLEN-1:0]          data,
    output logic                     hit,
    output logic                     hit_pending
);

    // Youngest (lowest index) enabled channel writing rs_reg wins; x0 never matches.
    always_comb begin
        data        = rf_data;
        hit         = 1'b0;
        hit_pending = 1'b0;
        if (rs_reg == '0) begin
            data = '0;
        end else begin
            for (int unsigned k = 0; k < NUM_FWD; k++) begin
                if (!hit && df_enable[k] && (df_reg[k*REG_W +: REG_W] == rs_reg)) begin
                    hit         = 1'b1;
                    hit_pending = df_pending[k];
                    data        = df_data[k*XLEN +: XLEN];
                end
            end
        end
    end

endmodule

// File: rtl/rv32i_hazard_ctrl.sv
// Forwarding, load-use stall and branch-flush controller beside the decode stage.
module rv32i_hazard_ctrl
    import rv32i_hazard_pkg::*;
#(
    parameter int unsigned XLEN         = XLEN_DEF,
    parameter int unsigned REG_W        = REG_W_DEF,
    parameter int unsigned NUM_FWD      = 3,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 32
) (
    input  logic                clk,
    input  logic                reset,
    rv32i_hazard_ctrl_if.slave  hz
);

    localparam int unsigned    CW         = flush_cnt_w(FLUSH_CYCLES);
    localparam logic [CW-1:0]  FLUSH_LOAD = CW'(FLUSH_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic rs1_hit, rs1_pend, rs2_hit, rs2_pend;
    logic hazard, flush, busy, flush_start, stall;

    rv32i_fwd_select #(.XLEN(XLEN), .REG_W(REG_W), .NUM_FWD(NUM_FWD)) u_fwd_rs1 (
        .rs_reg      (hz.id_rs1_reg),
        .rf_data     (hz.id_rs1_data),
        .df_enable   (hz.df_enable),
        .df_reg      (hz.df_reg),
        .df_data     (hz.df_data),
        .df_pending  (hz.df_pending),
        .data        (hz.rs1_fwd_data),
        .hit         (rs1_hit),
        .hit_pending (rs1_pend)
    );

    rv32i_fwd_select #(.XLEN(XLEN), .REG_W(REG_W), .NUM_FWD(NUM_FWD)) u_fwd_rs2 (
        .rs_reg      (hz.id_rs2_reg),
        .rf_data     (hz.id_rs2_data),
        .df_enable   (hz.df_enable),
        .df_reg      (hz.df_reg),
        .df_data     (hz.df_data),
        .df_pending  (hz.df_pending),
        .data        (hz.rs2_fwd_data),
        .hit         (rs2_hit),
        .hit_pending (rs2_pend)
    );

    // Load-use hazard: the youngest match for a used operand is still in flight.
    always_comb begin
        hazard = hz.id_valid & ((hz.id_rs1_used & rs1_hit & rs1_pend) |
                                (hz.id_rs2_used & rs2_hit & rs2_pend));
    end

    // Flush FSM: the taken-branch cycle flushes itself, FLUSH covers the remaining cycles.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        flush       = 1'b0;
        busy        = 1'b0;
        flush_start = 1'b0;
        case (state_q)
            RUN: begin
                if (hz.br_taken) begin
                    flush       = 1'b1;
                    flush_start = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d = FLUSH;
                        cnt_d   = FLUSH_LOAD;
                    end
                end
            end
            FLUSH: begin
                flush = 1'b1;
                busy  = 1'b1;
                cnt_d = cnt_q - CW'(1);
                // Counter hits 0 at the end of this cycle, so RUN resumes next cycle.
                if (cnt_q <= CW'(1)) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // Flush has priority over the load-use stall.
    always_comb begin
        stall = hazard & ~flush;
    end

    // Saturating performance counters.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (flush_start && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hz.stall_if_id = stall;
    assign hz.bubble_ex   = stall;
    assign hz.flush_if_id = flush;
    assign hz.busy        = busy;
    assign hz.stall_cnt   = stall_cnt_q;
    assign hz.flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_rv32i_hazard_ctrl.sv
// Self-checking bench for rv32i_hazard_ctrl: vector table, corner sequences, random vs model.
module tb_rv32i_hazard_ctrl;

    localparam int unsigned XL   = 32;
    localparam int unsigned RW   = 5;
    localparam int unsigned NF   = 3;
    localparam int unsigned FC_A = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;

    rv32i_hazard_ctrl_if #(.XLEN(XL), .REG_W(RW), .NUM_FWD(NF), .CNT_W(32)) ifa ();
    rv32i_hazard_ctrl_if #(.XLEN(XL), .REG_W(RW), .NUM_FWD(NF), .CNT_W(4))  ifb ();

    rv32i_hazard_ctrl #(.XLEN(XL), .REG_W(RW), .NUM_FWD(NF), .FLUSH_CYCLES(FC_A), .CNT_W(32)) dut_a (
        .clk   (clk),
        .reset (rst_a),
        .hz    (ifa)
    );

    rv32i_hazard_ctrl #(.XLEN(XL), .REG_W(RW), .NUM_FWD(NF), .FLUSH_CYCLES(4), .CNT_W(4)) dut_b (
        .clk   (clk),
        .reset (rst_b),
        .hz    (ifb)
    );

    int unsigned n_chk = 0;
    int unsigned n_err = 0;
    string       ctx   = "init";

    // Reference model state for instance A: flush cycles still owed, counter values.
    int              m_left  = 0;
    longint unsigned m_stall = 0;
    longint unsigned m_flush = 0;

    typedef struct {
        logic         valid;
        logic [4:0]   rs1, rs2;
        logic         u1, u2;
        logic [2:0]   en, pend;
        logic [14:0]  regs;
        logic [95:0]  data;
        logic [31:0]  rf1, rf2;
        logic [31:0]  x1, x2;
        logic         xstall;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", ctx, nm, act, exp);
        end
    endtask

    task automatic drive_a(input logic v, input logic [4:0] r1, input logic u1,
                           input logic [4:0] r2, input logic u2, input logic [2:0] en,
                           input logic [14:0] regs, input logic [95:0] data,
                           input logic [2:0] pend, input logic [31:0] rf1,
                           input logic [31:0] rf2, input logic br);
        ifa.id_valid    = v;
        ifa.id_rs1_reg  = r1;
        ifa.id_rs1_used = u1;
        ifa.id_rs2_reg  = r2;
        ifa.id_rs2_used = u2;
        ifa.df_enable   = en;
        ifa.df_reg      = regs;
        ifa.df_data     = data;
        ifa.df_pending  = pend;
        ifa.id_rs1_data = rf1;
        ifa.id_rs2_data = rf2;
        ifa.br_taken    = br;
    endtask

    task automatic idle_a();
        drive_a(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 3'b000, '0, '0, 3'b000, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic idle_b();
        ifb.id_valid    = 1'b0;
        ifb.id_rs1_reg  = '0;
        ifb.id_rs1_used = 1'b0;
        ifb.id_rs2_reg  = '0;
        ifb.id_rs2_used = 1'b0;
        ifb.id_rs1_data = '0;
        ifb.id_rs2_data = '0;
        ifb.df_enable   = '0;
        ifb.df_reg      = '0;
        ifb.df_data     = '0;
        ifb.df_pending  = '0;
        ifb.br_taken    = 1'b0;
    endtask

    // Operand as the architecture defines it: youngest enabled writer, else register file.
    function automatic void m_operand(input logic [4:0] r, input logic [31:0] rf,
                                      output logic [31:0] d, output bit pend);
        d    = rf;
        pend = 1'b0;
        if (r == 5'd0) begin
            d = 32'h0;
            return;
        end
        for (int k = NF - 1; k >= 0; k--) begin
            if (ifa.df_enable[k] && (ifa.df_reg[k*RW +: RW] == r)) begin
                d    = ifa.df_data[k*XL +: XL];
                pend = ifa.df_pending[k];
            end
        end
    endfunction

    // Compare every output of A with the model, then advance model and clock one cycle.
    task automatic tick_a();
        logic [31:0] e1, e2;
        bit p1, p2, hzd, bsy, fl, st;
        #1;
        m_operand(ifa.id_rs1_reg, ifa.id_rs1_data, e1, p1);
        m_operand(ifa.id_rs2_reg, ifa.id_rs2_data, e2, p2);
        hzd = ifa.id_valid && ((ifa.id_rs1_used && p1) || (ifa.id_rs2_used && p2));
        bsy = (m_left > 0);
        fl  = bsy || ifa.br_taken;
        st  = hzd && !fl;
        chk("m_rs1",       ifa.rs1_fwd_data, e1);
        chk("m_rs2",       ifa.rs2_fwd_data, e2);
        chk("m_stall",     ifa.stall_if_id,  st);
        chk("m_bubble",    ifa.bubble_ex,    st);
        chk("m_flush",     ifa.flush_if_id,  fl);
        chk("m_busy",      ifa.busy,         bsy);
        chk("m_stall_cnt", ifa.stall_cnt,    m_stall);
        chk("m_flush_cnt", ifa.flush_cnt,    m_flush);
        if (rst_a) begin
            m_left  = 0;
            m_stall = 0;
            m_flush = 0;
        end else begin
            if (st && m_stall < 64'hFFFF_FFFF) m_stall++;
            if (bsy) begin
                m_left--;
            end else if (ifa.br_taken) begin
                m_left = FC_A - 1;
                if (m_flush < 64'hFFFF_FFFF) m_flush++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic reset_a();
        rst_a = 1'b1;
        idle_a();
        tick_a();
        rst_a = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [14:0] rregs;
        logic [95:0] rdata;

        rst_a = 1'b1;
        rst_b = 1'b1;
        idle_a();
        idle_b();
        @(posedge clk);
        #1;

        // Reset state
        ctx = "reset";
        chk("busy",      ifa.busy,        1'b0);
        chk("flush",     ifa.flush_if_id, 1'b0);
        chk("stall_cnt", ifa.stall_cnt,   32'd0);
        chk("flush_cnt", ifa.flush_cnt,   32'd0);
        chk("b_busy",    ifb.busy,        1'b0);
        tick_a();
        rst_a = 1'b0;
        rst_b = 1'b0;

        // Vector table: operand resolution and hazard detection
        tbl[0] = '{1'b1, 5'd5, 5'd3, 1'b1, 1'b1, 3'b101, 3'b000, {5'd5, 5'd9, 5'd5},
                   {32'h12345678, 32'h0, 32'hAAAA0000}, 32'h11111111, 32'h22222222,
                   32'hAAAA0000, 32'h22222222, 1'b0};
        tbl[1] = '{1'b1, 5'd4, 5'd0, 1'b1, 1'b1, 3'b001, 3'b000, {5'd0, 5'd0, 5'd0},
                   {32'h0, 32'h0, 32'hDEADBEEF}, 32'h44444444, 32'h55555555,
                   32'h44444444, 32'h0, 1'b0};
        tbl[2] = '{1'b1, 5'd6, 5'd1, 1'b1, 1'b1, 3'b011, 3'b010, {5'd0, 5'd6, 5'd6},
                   {32'h0, 32'h0BAD0BAD, 32'h600D600D}, 32'h61616161, 32'h12121212,
                   32'h600D600D, 32'h12121212, 1'b0};
        tbl[3] = '{1'b1, 5'd2, 5'd8, 1'b1, 1'b1, 3'b100, 3'b100, {5'd8, 5'd0, 5'd0},
                   {32'hCAFEF00D, 32'h0, 32'h0}, 32'h23232323, 32'h34343434,
                   32'h23232323, 32'hCAFEF00D, 1'b1};
        tbl[4] = '{1'b0, 5'd2, 5'd8, 1'b1, 1'b1, 3'b100, 3'b100, {5'd8, 5'd0, 5'd0},
                   {32'hCAFEF00D, 32'h0, 32'h0}, 32'h23232323, 32'h34343434,
                   32'h23232323, 32'hCAFEF00D, 1'b0};
        tbl[5] = '{1'b1, 5'd2, 5'd8, 1'b1, 1'b0, 3'b100, 3'b100, {5'd8, 5'd0, 5'd0},
                   {32'hCAFEF00D, 32'h0, 32'h0}, 32'h23232323, 32'h34343434,
                   32'h23232323, 32'hCAFEF00D, 1'b0};
        tbl[6] = '{1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 3'b000, 3'b111, {5'd7, 5'd7, 5'd7},
                   {32'h1, 32'h2, 32'h3}, 32'h70707070, 32'h71717171,
                   32'h70707070, 32'h71717171, 1'b0};
        tbl[7] = '{1'b1, 5'd9, 5'd10, 1'b1, 1'b1, 3'b110, 3'b010, {5'd9, 5'd10, 5'd0},
                   {32'h99999999, 32'hAAAA1010, 32'h0}, 32'h1, 32'h2,
                   32'h99999999, 32'hAAAA1010, 1'b1};

        for (int i = 0; i < 8; i++) begin
            ctx = $sformatf("vec%0d", i);
            drive_a(tbl[i].valid, tbl[i].rs1, tbl[i].u1, tbl[i].rs2, tbl[i].u2, tbl[i].en,
                    tbl[i].regs, tbl[i].data, tbl[i].pend, tbl[i].rf1, tbl[i].rf2, 1'b0);
            #1;
            chk("rs1",    ifa.rs1_fwd_data, tbl[i].x1);
            chk("rs2",    ifa.rs2_fwd_data, tbl[i].x2);
            chk("stall",  ifa.stall_if_id,  tbl[i].xstall);
            chk("bubble", ifa.bubble_ex,    tbl[i].xstall);
            tick_a();
        end

        // Load-use: pending on channel 0, then the same load resolved on channel 1
        ctx = "load_use";
        reset_a();
        drive_a(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 3'b001, {5'd0, 5'd0, 5'd7},
                {32'h0, 32'h0, 32'h77777777}, 3'b001, 32'h0, 32'h0, 1'b0);
        #1;
        chk("stall",  ifa.stall_if_id, 1'b1);
        chk("bubble", ifa.bubble_ex,   1'b1);
        tick_a();
        drive_a(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 3'b010, {5'd0, 5'd7, 5'd3},
                {32'h0, 32'h77777777, 32'h0}, 3'b000, 32'h0, 32'h0, 1'b0);
        #1;
        chk("rs1",       ifa.rs1_fwd_data, 32'h77777777);
        chk("stall2",    ifa.stall_if_id,  1'b0);
        chk("stall_cnt", ifa.stall_cnt,    32'd1);
        tick_a();

        // Branch flush with a wrong-path branch in the FLUSH cycle
        ctx = "branch";
        reset_a();
        ifa.br_taken = 1'b1;
        #1;
        chk("flushN", ifa.flush_if_id, 1'b1);
        chk("busyN",  ifa.busy,        1'b0);
        tick_a();
        ifa.br_taken = 1'b1;
        #1;
        chk("flushN1",     ifa.flush_if_id, 1'b1);
        chk("busyN1",      ifa.busy,        1'b1);
        chk("flush_cntN1", ifa.flush_cnt,   32'd1);
        tick_a();
        ifa.br_taken = 1'b0;
        #1;
        chk("flushN2",     ifa.flush_if_id, 1'b0);
        chk("busyN2",      ifa.busy,        1'b0);
        chk("flush_cntN2", ifa.flush_cnt,   32'd1);
        tick_a();

        // Flush over stall
        ctx = "flush_over_stall";
        reset_a();
        drive_a(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 3'b001, {5'd0, 5'd0, 5'd7},
                {32'h0, 32'h0, 32'h77777777}, 3'b001, 32'h0, 32'h0, 1'b1);
        #1;
        chk("flush",  ifa.flush_if_id, 1'b1);
        chk("stall",  ifa.stall_if_id, 1'b0);
        chk("bubble", ifa.bubble_ex,   1'b0);
        tick_a();
        ifa.br_taken = 1'b0;
        #1;
        chk("stall1",     ifa.stall_if_id, 1'b0);
        chk("stall_cnt1", ifa.stall_cnt,   32'd0);
        tick_a();
        #1;
        chk("stall2", ifa.stall_if_id, 1'b1);
        tick_a();

        // Randomized traffic against the model
        ctx = "random";
        for (int n = 0; n < 400; n++) begin
            rst_a = ($urandom_range(0, 49) == 0);
            for (int k = 0; k < 3; k++) begin
                rregs[k*5 +: 5] = 5'($urandom_range(0, 3));
                rdata[k*32 +: 32] = $urandom;
            end
            drive_a(1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom),
                    5'($urandom_range(0, 3)), 1'($urandom), 3'($urandom), rregs, rdata,
                    3'($urandom), $urandom, $urandom, ($urandom_range(0, 5) == 0));
            tick_a();
        end
        rst_a = 1'b0;
        idle_a();

        // Instance B: reset in the middle of a 4-cycle flush
        ctx = "b_reset_flush";
        @(posedge clk);
        #1;
        ifb.br_taken = 1'b1;
        #1;
        chk("flushN", ifb.flush_if_id, 1'b1);
        chk("busyN",  ifb.busy,        1'b0);
        @(posedge clk);
        #1;
        ifb.br_taken = 1'b0;
        chk("busyN1",      ifb.busy,        1'b1);
        chk("flushN1",     ifb.flush_if_id, 1'b1);
        chk("flush_cntN1", ifb.flush_cnt,   4'd1);
        rst_b = 1'b1;
        @(posedge clk);
        #1;
        rst_b = 1'b0;
        chk("busyN2",      ifb.busy,        1'b0);
        chk("flushN2",     ifb.flush_if_id, 1'b0);
        chk("flush_cntN2", ifb.flush_cnt,   4'd0);
        chk("stall_cntN2", ifb.stall_cnt,   4'd0);
        @(posedge clk);
        #1;
        chk("busyN3", ifb.busy, 1'b0);

        // Instance B: stall counter saturation at 15
        ctx = "b_saturate";
        ifb.id_valid    = 1'b1;
        ifb.id_rs1_reg  = 5'd7;
        ifb.id_rs1_used = 1'b1;
        ifb.df_enable   = 3'b001;
        ifb.df_reg      = {5'd0, 5'd0, 5'd7};
        ifb.df_pending  = 3'b001;
        #1;
        chk("stall", ifb.stall_if_id, 1'b1);
        for (int n = 0; n < 14; n++) @(posedge clk);
        #1;
        chk("stall_cnt14", ifb.stall_cnt, 4'd14);
        for (int n = 0; n < 6; n++) @(posedge clk);
        #1;
        chk("stall_cnt20", ifb.stall_cnt,   4'd15);
        chk("stall20",     ifb.stall_if_id, 1'b1);
        idle_b();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/rv32i_hazard_ctrl.md
Name: rv32i_hazard_ctrl

Overview:
- Parametrised forwarding, stall and flush controller for the RV32I pipeline.
- Replaces the three fixed df_ex/df_mem/df_wb channels with NUM_FWD generic forwarding channels.
- Adds load-use stall detection, a branch-flush state machine and saturating performance counters.
- Sits beside the decode stage. It feeds the decode stage's operand muxes and drives stall/bubble/flush to the fetch, decode and execute stages.

Parameters:
- XLEN, 32, datapath width.
- REG_W, 5, register address width.
- NUM_FWD, 3, number of forwarding channels. Index 0 is the youngest (EX), ascending index means older.
- FLUSH_CYCLES, 2, number of cycles flush_if_id is held after a taken branch. Legal range 1..15.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- id_valid  in  1  decode stage holds a real instruction
- id_rs1_reg, id_rs2_reg  in  REG_W  source register addresses
- id_rs1_used, id_rs2_used  in  1  instruction reads that source
- id_rs1_data, id_rs2_data  in  XLEN  register-file read data
- df_enable  in  NUM_FWD  channel k carries a pending writeback
- df_reg  in  NUM_FWD*REG_W  destination register of channel k (packed, k*REG_W LSB)
- df_data  in  NUM_FWD*XLEN  result data of channel k
- df_pending  in  NUM_FWD  channel k result not yet available (load in flight)
- br_taken  in  1  EX resolved a taken branch/jump
- rs1_fwd_data, rs2_fwd_data  out  XLEN  resolved operands
- stall_if_id  out  1  hold PC and the IF/ID register
- bubble_ex  out  1  insert a NOP into ID/EX
- flush_if_id  out  1  squash IF/ID contents
- stall_cnt, flush_cnt  out  CNT_W  performance counters
- busy  out  1  FSM is in FLUSH

Behaviour:
Clocking and reset:
- Single clock.
- Reset is synchronous and active-high.
- On reset: FSM goes to RUN, the flush counter is 0, stall_cnt=0, flush_cnt=0, busy=0.

Operand resolution (combinational, zero latency):
- Per operand, pick the lowest k with df_enable[k] and df_reg[k]==rsX_reg.
- rsX_reg==0 always yields 0 and never matches a channel.
- With no match, output id_rsX_data.

Load-use hazard (combinational):
- hazard = id_valid & rsX_used & (matched channel has df_pending), for either operand.
- Only the youngest matching channel is considered. An older pending match shadowed by a younger non-pending match causes no stall.

FSM states RUN, FLUSH:
- RUN, br_taken=1:
  - flush_if_id=1 in the same cycle.
  - Go to FLUSH with counter=FLUSH_CYCLES-1, or stay in RUN if FLUSH_CYCLES==1.
  - flush_cnt+1.
- FLUSH: flush_if_id=1 and busy=1. Counter decrements each cycle. Return to RUN the cycle after the counter reaches 0.
- br_taken while in FLUSH is ignored (wrong-path). It does not restart the counter or increment flush_cnt.

Priority:
- Flush overrides stall. While flush_if_id=1, stall_if_id=0 and bubble_ex=0.
- Otherwise, on hazard: stall_if_id=1 and bubble_ex=1.

Counters:
- stall_cnt increments on every cycle with stall_if_id=1.
- Both counters saturate at all-ones and do not wrap.

Reset and conditions:
- Reset mid-FLUSH returns to RUN in the next cycle and clears all counters.
- id_valid=0 suppresses stalls but not flushes.

Decomposition:
- Package rv32i_hazard_pkg holds:
  - the state enum (RUN, FLUSH)
  - REG_W and XLEN default constants
  - function flush_cnt_w(FLUSH_CYCLES) returning the counter width
- Sub-module rv32i_fwd_select performs priority match and mux for one operand.
  - Parameters: XLEN, REG_W, NUM_FWD.
  - Outputs: data, hit, hit_pending.
  - Instantiated twice, once for rs1 and once for rs2.

Test Plan:
1. Forward priority: NUM_FWD=3, rs1=5, channels 0 and 2 both write x5 with 0xAAAA0000 and 0x12345678 -> rs1_fwd_data=0xAAAA0000, no stall.
2. x0 guard: rs2=0, channel 0 writes x0 with 0xDEADBEEF -> rs2_fwd_data=0x0.
3. Load-use: channel 0 writes x7 with pending=1, rs1=7 used -> stall_if_id=1 and bubble_ex=1 for one cycle. Next cycle the same load is on channel 1 with pending=0 -> forwards its data, stall deasserts, stall_cnt=1.
4. Branch flush: FLUSH_CYCLES=2, br_taken pulse at cycle N -> flush_if_id high in cycles N and N+1, busy high in N+1, flush_cnt=1. A second br_taken at N+1 is ignored.
5. Flush over stall: br_taken and a load-use hazard in the same cycle -> flush_if_id=1, stall_if_id=0, stall_cnt unchanged.
6. Reset and saturation: assert reset at cycle N+1 of a FLUSH_CYCLES=4 flush -> RUN and counters 0 next cycle. Separately, with CNT_W=4, 20 stall cycles -> stall_cnt holds at 15.
